// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the execute stage: instruction codes, ALU
// operation selects, condition codes, CC bit positions and the condition
// evaluator used for jXX/cmovXX.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   localparam logic [3:0] C_ALWAYS = 4'h0;
   localparam logic [3:0] C_LE     = 4'h1;
   localparam logic [3:0] C_L      = 4'h2;
   localparam logic [3:0] C_E      = 4'h3;
   localparam logic [3:0] C_NE     = 4'h4;
   localparam logic [3:0] C_GE     = 4'h5;
   localparam logic [3:0] C_G      = 4'h6;

   // CC register layout is {ZF,SF,OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // Evaluates a jXX/cmovXX condition against the CC register; unknown
   // condition codes never take the branch or the move.
   function automatic logic evalCond(input logic [3:0] ifun, input logic [2:0] ccVal);
      logic zf;
      logic sf;
      logic of;
      logic taken;
      zf = ccVal[CC_ZF];
      sf = ccVal[CC_SF];
      of = ccVal[CC_OF];
      case (ifun)
         C_ALWAYS: taken = 1'b1;
         C_LE:     taken = (sf ^ of) | zf;
         C_L:      taken = sf ^ of;
         C_E:      taken = zf;
         C_NE:     taken = ~zf;
         C_GE:     taken = ~(sf ^ of);
         C_G:      taken = ~(sf ^ of) & ~zf;
         default:  taken = 1'b0;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/y86_execute_stage_alu.sv
// Combinational Y86-64 ALU: computes a OP b and flags two's-complement
// overflow for add and subtract.
module y86_execute_stage_alu
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   output logic [WIDTH-1:0] ans,
   output logic             overflow,
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b
);

   // Overflow is judged from operand and result sign bits; logical ops never overflow
   always_comb begin
      ans      = '0;
      overflow = 1'b0;
      case (sel)
         ALU_ADD: begin
            ans      = a + b;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (ans[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            ans      = a - b;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (ans[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: ans = a & b;
         ALU_XOR: ans = a ^ b;
         default: ans = '0;
      endcase
   end

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 execute stage: one register stage between decode and memory with a
// valid/ready handshake on both sides. It selects the ALU operands, registers
// valE and the branch/cmov condition, and owns the {ZF,SF,OF} CC register.
module y86_execute_stage
   import y86_pkg::*;
#(
   parameter int WIDTH      = 64,
   parameter int STACK_STEP = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_icode,
   input  logic [3:0]       in_ifun,
   input  logic [WIDTH-1:0] in_valA,
   input  logic [WIDTH-1:0] in_valB,
   input  logic [WIDTH-1:0] in_valC,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_icode,
   output logic [3:0]       out_ifun,
   output logic [WIDTH-1:0] out_valE,
   output logic [WIDTH-1:0] out_valA,
   output logic             out_cnd,
   output logic [2:0]       cc,
   output logic             halted,
   output logic             err
);

   localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(STACK_STEP);
   localparam logic [WIDTH-1:0] STEP_NEG = -STEP_POS;

   logic [WIDTH-1:0] aluA;
   logic [WIDTH-1:0] aluB;
   logic [WIDTH-1:0] aluAns;
   logic [1:0]       aluSel;
   logic             aluOvf;

   logic             out_valid_q;
   logic [3:0]       out_icode_q;
   logic [3:0]       out_ifun_q;
   logic [WIDTH-1:0] out_valE_q;
   logic [WIDTH-1:0] out_valA_q;
   logic             out_cnd_q;
   logic [2:0]       cc_q;
   logic [2:0]       cc_d;
   logic             cnd_d;
   logic             halted_q;
   logic             err_q;

   logic             isOpq;
   logic             isCond;
   logic             isBad;
   logic             isStop;
   logic             accept;

   y86_execute_stage_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .ans      (aluAns),
      .overflow (aluOvf),
      .sel      (aluSel),
      .a        (aluA),
      .b        (aluB)
   );

   // Operand routing per icode; anything without an ALU job adds 0+0 so valE is 0
   always_comb begin
      aluA   = '0;
      aluB   = '0;
      aluSel = ALU_ADD;
      case (in_icode)
         I_OPQ: begin
            aluA   = in_valB;
            aluB   = in_valA;
            aluSel = in_ifun[1:0];
         end
         I_RRMOVQ: aluB = in_valA;
         I_IRMOVQ: aluB = in_valC;
         I_RMMOVQ, I_MRMOVQ: begin
            aluA = in_valB;
            aluB = in_valC;
         end
         I_CALL, I_PUSHQ: begin
            aluA = in_valB;
            aluB = STEP_NEG;
         end
         I_RET, I_POPQ: begin
            aluA = in_valB;
            aluB = STEP_POS;
         end
         I_HALT, I_NOP, I_JXX: begin
            aluA = '0;
            aluB = '0;
         end
         default: begin
            aluA = '0;
            aluB = '0;
         end
      endcase
   end

   // Instruction legality, condition outcome and the CC value an OPq would leave behind
   always_comb begin
      isOpq  = (in_icode == I_OPQ);
      isCond = (in_icode == I_JXX) || (in_icode == I_RRMOVQ);
      isBad  = (isOpq && (in_ifun > 4'd3))
             || (isCond && (in_ifun > C_G))
             || (in_icode > I_POPQ);
      isStop = isBad || (in_icode == I_HALT);
      cnd_d  = isCond && evalCond(in_ifun, cc_q);
      cc_d   = cc_q;
      if (isOpq && !isBad) begin
         cc_d[CC_ZF] = (aluAns == '0);
         cc_d[CC_SF] = aluAns[WIDTH-1];
         cc_d[CC_OF] = ((aluSel == ALU_ADD) || (aluSel == ALU_SUB)) && aluOvf;
      end
   end

   assign in_ready = ~halted_q & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   // Result register, CC register and sticky halt/error flags; a new accept overwrites the entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_icode_q <= '0;
         out_ifun_q  <= '0;
         out_valE_q  <= '0;
         out_valA_q  <= '0;
         out_cnd_q   <= 1'b0;
         cc_q        <= 3'b100;
         halted_q    <= 1'b0;
         err_q       <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_icode_q <= in_icode;
         out_ifun_q  <= in_ifun;
         out_valE_q  <= aluAns;
         out_valA_q  <= in_valA;
         out_cnd_q   <= cnd_d;
         cc_q        <= cc_d;
         if (isStop) halted_q <= 1'b1;
         if (isBad)  err_q    <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_icode = out_icode_q;
   assign out_ifun  = out_ifun_q;
   assign out_valE  = out_valE_q;
   assign out_valA  = out_valA_q;
   assign out_cnd   = out_cnd_q;
   assign cc        = cc_q;
   assign halted    = halted_q;
   assign err       = err_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Self-checking bench for the Y86-64 execute stage: directed scenarios with
// literal expectations plus randomized traffic, all compared every cycle
// against an instruction-level reference model.
module tb_y86_execute_stage;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic        inReady;
   logic [3:0]  inIcode;
   logic [3:0]  inIfun;
   logic [63:0] inValA;
   logic [63:0] inValB;
   logic [63:0] inValC;
   logic        outValid;
   logic        outReady;
   logic [3:0]  outIcode;
   logic [3:0]  outIfun;
   logic [63:0] outValE;
   logic [63:0] outValA;
   logic        outCnd;
   logic [2:0]  ccOut;
   logic        haltedOut;
   logic        errOut;

   int total = 0;
   int bad   = 0;

   // Reference model state (instruction-level view of the stage)
   logic        mValid  = 1'b0;
   logic [3:0]  mIcode  = 4'h0;
   logic [3:0]  mIfun   = 4'h0;
   logic [63:0] mValE   = 64'h0;
   logic [63:0] mValA   = 64'h0;
   logic        mCnd    = 1'b0;
   logic        mZf     = 1'b1;
   logic        mSf     = 1'b0;
   logic        mOf     = 1'b0;
   logic        mHalted = 1'b0;
   logic        mErr    = 1'b0;
   logic        mAccept = 1'b0;

   y86_execute_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .in_icode  (inIcode),
      .in_ifun   (inIfun),
      .in_valA   (inValA),
      .in_valB   (inValB),
      .in_valC   (inValC),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_icode (outIcode),
      .out_ifun  (outIfun),
      .out_valE  (outValE),
      .out_valA  (outValA),
      .out_cnd   (outCnd),
      .cc        (ccOut),
      .halted    (haltedOut),
      .err       (errOut)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic logic condHolds(input logic [3:0] fn, input logic zf, input logic sf, input logic of);
      logic lessThan;
      lessThan = (sf != of);
      if (fn == 4'd0) return 1'b1;
      if (fn == 4'd1) return lessThan || zf;
      if (fn == 4'd2) return lessThan;
      if (fn == 4'd3) return zf;
      if (fn == 4'd4) return !zf;
      if (fn == 4'd5) return !lessThan;
      if (fn == 4'd6) return !lessThan && !zf;
      return 1'b0;
   endfunction

   // Reference model: reacts to the same handshake rules on each rising edge
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mValid = 1'b0; mIcode = 4'h0; mIfun = 4'h0; mValE = 64'h0; mValA = 64'h0;
            mCnd = 1'b0; mZf = 1'b1; mSf = 1'b0; mOf = 1'b0; mHalted = 1'b0; mErr = 1'b0;
            mAccept = 1'b0;
         end else begin
            mAccept = inValid && !mHalted && (!mValid || outReady);
            if (mAccept) begin
               logic [63:0] res;
               logic        cndNew;
               logic        illegal;
               logic signed [64:0] exact;
               res = 64'h0; cndNew = 1'b0; illegal = 1'b0;
               if (inIcode == 4'h6) begin
                  case (inIfun[1:0])
                     2'd0: begin
                        res   = inValB + inValA;
                        exact = $signed({inValB[63], inValB}) + $signed({inValA[63], inValA});
                     end
                     2'd1: begin
                        res   = inValB - inValA;
                        exact = $signed({inValB[63], inValB}) - $signed({inValA[63], inValA});
                     end
                     2'd2: begin
                        res   = inValB & inValA;
                        exact = $signed({res[63], res});
                     end
                     default: begin
                        res   = inValB ^ inValA;
                        exact = $signed({res[63], res});
                     end
                  endcase
                  if (inIfun > 4'd3) illegal = 1'b1;
                  else begin
                     mZf = (res == 64'h0);
                     mSf = res[63];
                     mOf = (exact[64] != exact[63]);
                  end
               end else if (inIcode == 4'h2 || inIcode == 4'h7) begin
                  cndNew = condHolds(inIfun, mZf, mSf, mOf);
                  res = (inIcode == 4'h2) ? inValA : 64'h0;
                  if (inIfun > 4'd6) illegal = 1'b1;
               end else if (inIcode == 4'h3) res = inValC;
               else if (inIcode == 4'h4 || inIcode == 4'h5) res = inValB + inValC;
               else if (inIcode == 4'h8 || inIcode == 4'hA) res = inValB - 64'd8;
               else if (inIcode == 4'h9 || inIcode == 4'hB) res = inValB + 64'd8;
               else if (inIcode > 4'hB) illegal = 1'b1;
               mValid = 1'b1; mIcode = inIcode; mIfun = inIfun; mValE = res;
               mValA = inValA; mCnd = cndNew;
               if (illegal) begin
                  mErr = 1'b1;
                  mHalted = 1'b1;
               end
               if (inIcode == 4'h0) mHalted = 1'b1;
            end else if (outReady) begin
               mValid = 1'b0;
            end
         end
      end
   end

   // Compare process: every falling edge out of reset, DUT against model
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            checkOutput("out_valid", 64'(outValid), 64'(mValid));
            checkOutput("in_ready", 64'(inReady), 64'(!mHalted && (!mValid || outReady)));
            checkOutput("cc", 64'(ccOut), 64'({mZf, mSf, mOf}));
            checkOutput("halted", 64'(haltedOut), 64'(mHalted));
            checkOutput("err", 64'(errOut), 64'(mErr));
            if (mValid) begin
               checkOutput("out_icode", 64'(outIcode), 64'(mIcode));
               checkOutput("out_ifun", 64'(outIfun), 64'(mIfun));
               checkOutput("out_valE", outValE, mValE);
               checkOutput("out_valA", outValA, mValA);
               checkOutput("out_cnd", 64'(outCnd), 64'(mCnd));
            end
         end
      end
   end

   // Presents one instruction and waits (bounded) until the model sees it accepted
   task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
      bit done;
      done = 1'b0;
      inIcode = ic; inIfun = fn; inValA = a; inValB = b; inValC = c; inValid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk);
         #1;
         if (mAccept) begin
            done = 1'b1;
            break;
         end
      end
      total++;
      if (!done) begin
         bad++;
         $display("[TB] FAIL accept_timeout: icode %h not accepted within 20 cycles", ic);
      end
   endtask

   task automatic doReset(input bit withChecks);
      inValid = 1'b0;
      rst_n = 1'b0;
      #2;
      if (withChecks) begin
         checkOutput("reset out_valid", 64'(outValid), 64'd0);
         checkOutput("reset cc", 64'(ccOut), 64'b100);
         checkOutput("reset halted", 64'(haltedOut), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios then randomized traffic
   initial begin
      rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
      inIcode = 4'h0; inIfun = 4'h0; inValA = '0; inValB = '0; inValC = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset out_valE", outValE, 64'd0);
      checkOutput("reset out_icode", 64'(outIcode), 64'd0);
      checkOutput("reset err", 64'(errOut), 64'd0);
      rst_n = 1'b1;
      #1;
      checkOutput("reset in_ready", 64'(inReady), 64'd1);

      // addq then je
      applyStimulus(4'h6, 4'h0, 64'd10, 64'd19, 64'd0);
      checkOutput("addq valE", outValE, 64'd29);
      checkOutput("addq cc", 64'(ccOut), 64'b000);
      checkOutput("model addq valE", mValE, 64'd29);
      applyStimulus(4'h7, 4'h3, 64'd0, 64'd0, 64'h40);
      checkOutput("je cnd", 64'(outCnd), 64'd0);

      // subq overflow, then jl and jg
      applyStimulus(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
      checkOutput("subq valE", outValE, 64'h7FFF_FFFF_FFFF_FFFF);
      checkOutput("subq cc", 64'(ccOut), 64'b001);
      checkOutput("model subq cc", 64'({mZf, mSf, mOf}), 64'b001);
      applyStimulus(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
      checkOutput("jl cnd", 64'(outCnd), 64'd1);
      applyStimulus(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
      checkOutput("jg cnd", 64'(outCnd), 64'd0);

      // xorq to zero then cmove
      applyStimulus(4'h6, 4'h3, 64'h5A, 64'h5A, 64'd0);
      checkOutput("xorq valE", outValE, 64'd0);
      checkOutput("xorq cc", 64'(ccOut), 64'b100);
      applyStimulus(4'h2, 4'h3, 64'h1234, 64'd0, 64'd0);
      checkOutput("cmove cnd", 64'(outCnd), 64'd1);
      checkOutput("cmove valE", outValE, 64'h1234);

      // push/pop stack pointer adjustment
      applyStimulus(4'hA, 4'h0, 64'h77, 64'h100, 64'd0);
      checkOutput("pushq valE", outValE, 64'hF8);
      applyStimulus(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
      checkOutput("popq valE", outValE, 64'h100);
      checkOutput("popq cc", 64'(ccOut), 64'b100);

      // Backpressure: three stalled cycles, then back-to-back transfers
      outReady = 1'b0;
      inIcode = 4'h6; inIfun = 4'h0; inValA = 64'd2; inValB = 64'd1; inValC = 64'd0; inValid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("stall in_ready", 64'(inReady), 64'd0);
      checkOutput("stall valE", outValE, 64'h100);
      checkOutput("stall icode", 64'(outIcode), 64'hB);
      checkOutput("stall cc", 64'(ccOut), 64'b100);
      outReady = 1'b1;
      applyStimulus(4'h6, 4'h0, 64'd2, 64'd1, 64'd0);
      checkOutput("release valE", outValE, 64'd3);
      applyStimulus(4'h3, 4'h0, 64'd0, 64'd0, 64'hABCD);
      checkOutput("irmovq valE", outValE, 64'hABCD);
      inValid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("drain out_valid", 64'(outValid), 64'd0);

      // Halt blocks the input forever
      applyStimulus(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
      checkOutput("halt icode", 64'(outIcode), 64'd0);
      checkOutput("halt halted", 64'(haltedOut), 64'd1);
      inIcode = 4'h1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("halt in_ready", 64'(inReady), 64'd0);
      checkOutput("halt err", 64'(errOut), 64'd0);
      doReset(1'b1);

      // Invalid icode sets err
      applyStimulus(4'hC, 4'h0, 64'd0, 64'd0, 64'd0);
      checkOutput("invalid err", 64'(errOut), 64'd1);
      checkOutput("invalid halted", 64'(haltedOut), 64'd1);
      doReset(1'b1);

      // Reset in the middle of a stall
      applyStimulus(4'h6, 4'h0, 64'd10, 64'd19, 64'd0);
      outReady = 1'b0;
      inIcode = 4'h6; inIfun = 4'h1; inValA = 64'd3; inValB = 64'd3; inValid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("pre-reset cc", 64'(ccOut), 64'b000);
      doReset(1'b1);
      outReady = 1'b1;

      // Randomized traffic with occasional halts and illegal encodings
      for (int it = 0; it < 800; it++) begin
         int r;
         r = int'($urandom_range(0, 99));
         inValid  = ($urandom_range(0, 3) != 0);
         outReady = ($urandom_range(0, 3) != 0);
         if (r < 2) inIcode = 4'h0;
         else if (r < 4) inIcode = 4'(12 + $urandom_range(0, 3));
         else inIcode = 4'(1 + $urandom_range(0, 10));
         if (inIcode == 4'h6) inIfun = ($urandom_range(0, 19) == 0) ? 4'(4 + $urandom_range(0, 11)) : 4'($urandom_range(0, 3));
         else if (inIcode == 4'h2 || inIcode == 4'h7) inIfun = ($urandom_range(0, 19) == 0) ? 4'(7 + $urandom_range(0, 8)) : 4'($urandom_range(0, 6));
         else inIfun = 4'h0;
         inValA = {$urandom, $urandom};
         inValB = ($urandom_range(0, 4) == 0) ? inValA : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) inValB = {1'b1, 63'($urandom)};
         inValC = {$urandom, $urandom};
         @(posedge clk);
         #1;
         if (mHalted) doReset(1'b0);
      end

      inValid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
